// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : i2c_pkg                                                          |
// | Shared state encoding and protocol constants for the I2C register slave.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    PTR       = 3'd2,
    WRITE     = 3'd3,
    READ_PREP = 3'd4,
    READ      = 3'd5,
    IGNORE    = 3'd6
  } i2c_state_t;

  localparam logic       I2C_RW_WRITE  = 1'b0;
  localparam logic       I2C_RW_READ   = 1'b1;
  localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

  function automatic logic addr_match(input logic [7:0] rx, input logic [6:0] dev);
    return rx[7:1] == dev;
  endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_slave_reg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : i2c_slave_reg_sequencer                                          |
// | Sequences I2C byte events into register read/write strobes with pointer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2c_slave_reg_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h71,
  parameter int         REG_AW   = 4,
  parameter int         NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_byte_done,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_master_ack,
  output logic [7:0]        o_tx_byte,
  output logic              o_ack,
  output logic              o_busy,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [7:0]        i_reg_rdata
);

  localparam logic [8:0]        c_num_regs = 9'(NUM_REGS);
  localparam logic [REG_AW-1:0] c_last_ptr = REG_AW'(NUM_REGS - 1);

  i2c_state_t        r_state, w_state_nxt;
  logic [REG_AW-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
  logic [7:0]        r_tx_byte, w_tx_byte_nxt;
  logic              r_ack, w_ack_nxt;
  logic [REG_AW-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [7:0]        r_reg_wdata, w_reg_wdata_nxt;
  logic              r_reg_we, w_reg_we_nxt;
  logic              r_reg_re, w_reg_re_nxt;

  assign w_ptr_inc = (r_ptr == c_last_ptr) ? '0 : r_ptr + REG_AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_tx_byte   <= I2C_IDLE_BYTE;
      r_ack       <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_ack       <= w_ack_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_re    <= w_reg_re_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_tx_byte_nxt   = r_tx_byte;
    w_ack_nxt       = r_ack;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_reg_we_nxt    = 1'b0;
    w_reg_re_nxt    = 1'b0;

    // Bus conditions pre-empt any byte event arriving in the same cycle.
    if (i_stop) begin
      w_state_nxt = IDLE;
    end else if (i_start) begin
      w_state_nxt = ADDR;
    end else begin
      unique case (r_state)
        IDLE: ;
        ADDR: if (i_byte_done) begin
          if (!addr_match(i_rx_byte, DEV_ADDR)) begin
            w_ack_nxt     = 1'b0;
            w_tx_byte_nxt = I2C_IDLE_BYTE;
            w_state_nxt   = IGNORE;
          end else if (i_rx_byte[0] == I2C_RW_WRITE) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = PTR;
          end else begin
            w_ack_nxt      = 1'b1;
            w_reg_re_nxt   = 1'b1;
            w_reg_addr_nxt = r_ptr;
            w_state_nxt    = READ_PREP;
          end
        end
        PTR: if (i_byte_done) begin
          if ({1'b0, i_rx_byte} >= c_num_regs) begin
            w_ack_nxt     = 1'b0;
            w_tx_byte_nxt = I2C_IDLE_BYTE;
            w_state_nxt   = IGNORE;
          end else begin
            w_ptr_nxt   = i_rx_byte[REG_AW-1:0];
            w_ack_nxt   = 1'b1;
            w_state_nxt = WRITE;
          end
        end
        WRITE: if (i_byte_done) begin
          w_reg_we_nxt    = 1'b1;
          w_reg_addr_nxt  = r_ptr;
          w_reg_wdata_nxt = i_rx_byte;
          w_ack_nxt       = 1'b1;
          w_ptr_nxt       = w_ptr_inc;
        end
        // Read data is presented while the strobe is high; capture it here.
        READ_PREP: begin
          w_tx_byte_nxt = i_reg_rdata;
          w_ptr_nxt     = w_ptr_inc;
          w_state_nxt   = READ;
        end
        READ: if (i_byte_done) begin
          w_ack_nxt = 1'b0;
          if (i_master_ack) begin
            w_reg_re_nxt   = 1'b1;
            w_reg_addr_nxt = r_ptr;
            w_state_nxt    = READ_PREP;
          end else begin
            w_tx_byte_nxt = I2C_IDLE_BYTE;
            w_state_nxt   = IGNORE;
          end
        end
        IGNORE: if (i_byte_done) begin
          w_ack_nxt     = 1'b0;
          w_tx_byte_nxt = I2C_IDLE_BYTE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == PTR) || (r_state == WRITE) ||
                       (r_state == READ_PREP) || (r_state == READ);
  assign o_tx_byte   = r_tx_byte;
  assign o_ack       = r_ack;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_reg_re    = r_reg_re;

endmodule : i2c_slave_reg_sequencer
`default_nettype wire

// File: tb/tb_i2c_slave_reg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_i2c_slave_reg_sequencer                                       |
// | Directed and random byte-level stimulus against a transaction-level model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_i2c_slave_reg_sequencer;

  localparam int M_IDLE = 0, M_ADDR = 1, M_PTR = 2, M_WRITE = 3, M_READ = 4, M_IGN = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0, i_stop = 1'b0, i_byte_done = 1'b0, i_master_ack = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;

  logic [7:0] tx_a, wdata_a, rdata_a, tx_b, wdata_b, rdata_b;
  logic       ack_a, busy_a, we_a, re_a, ack_b, busy_b, we_b, re_b;
  logic [3:0] addr_a, addr_b;

  always #5 clk = ~clk;

  i2c_slave_reg_sequencer #(.DEV_ADDR(7'h71), .REG_AW(4), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_byte_done(i_byte_done), .i_rx_byte(i_rx_byte), .i_master_ack(i_master_ack),
    .o_tx_byte(tx_a), .o_ack(ack_a), .o_busy(busy_a), .o_reg_addr(addr_a),
    .o_reg_wdata(wdata_a), .o_reg_we(we_a), .o_reg_re(re_a), .i_reg_rdata(rdata_a));

  i2c_slave_reg_sequencer #(.DEV_ADDR(7'h71), .REG_AW(4), .NUM_REGS(12)) dut12 (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_byte_done(i_byte_done), .i_rx_byte(i_rx_byte), .i_master_ack(i_master_ack),
    .o_tx_byte(tx_b), .o_ack(ack_b), .o_busy(busy_b), .o_reg_addr(addr_b),
    .o_reg_wdata(wdata_b), .o_reg_we(we_b), .o_reg_re(re_b), .i_reg_rdata(rdata_b));

  // Register files behind each slave, plus strobe monitors.
  logic [7:0] rf_a [16];
  logic [7:0] rf_b [16];
  logic [7:0] rf_seed = 8'h00;
  int         we_cnt = 0, re_cnt = 0, we_cnt_b = 0;
  logic [3:0] last_we_addr = '0, last_re_b = '0;
  logic [7:0] last_we_data = '0;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37) ^ rf_seed;
  endfunction

  assign rdata_a = rf_a[addr_a];
  assign rdata_b = rf_b[addr_b];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        rf_a[i] <= init_val(i);
        rf_b[i] <= init_val(i);
      end
    end else begin
      if (we_a) rf_a[addr_a] <= wdata_a;
      if (we_b) rf_b[addr_b] <= wdata_b;
    end
    if (we_a) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= addr_a;
      last_we_data <= wdata_a;
    end
    if (re_a) re_cnt <= re_cnt + 1;
    if (we_b) we_cnt_b <= we_cnt_b + 1;
    if (re_b) last_re_b <= addr_b;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: protocol phase, pointer, register image, last ack/tx.
  int         m_st = M_IDLE;
  int         m_ptr = 0;
  logic [7:0] m_mem [16];
  logic       m_ack = 1'b0;
  bit         m_ack_known = 1'b1;
  logic [7:0] m_tx = 8'hFF;

  task automatic model_reset();
    m_st = M_IDLE; m_ptr = 0; m_ack = 1'b0; m_ack_known = 1'b1; m_tx = 8'hFF;
    for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
  endtask

  task automatic settle();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    settle();
    m_st = M_ADDR;
    chk("start_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic do_stop();
    @(negedge clk); i_stop = 1'b1;
    @(negedge clk); i_stop = 1'b0;
    settle();
    m_st = M_IDLE;
    chk("stop_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] b, input logic mack);
    int we0, re0, ewe, ere, ewa;
    bit chk_ack;
    we0 = we_cnt; re0 = re_cnt; ewe = 0; ere = 0; ewa = 0; chk_ack = 1'b1;
    @(negedge clk);
    i_rx_byte = b; i_master_ack = mack; i_byte_done = 1'b1;
    @(negedge clk); i_byte_done = 1'b0;
    settle();
    case (m_st)
      M_ADDR: begin
        m_ack_known = 1'b1;
        if (b[7:1] != 7'h71) begin
          m_ack = 1'b0; m_tx = 8'hFF; m_st = M_IGN;
        end else if (!b[0]) begin
          m_ack = 1'b1; m_st = M_PTR;
        end else begin
          m_ack = 1'b1; ere = 1; m_tx = m_mem[m_ptr];
          m_ptr = (m_ptr + 1) % 16; m_st = M_READ;
        end
      end
      M_PTR: begin
        m_ack_known = 1'b1;
        if (b >= 8'd16) begin
          m_ack = 1'b0; m_tx = 8'hFF; m_st = M_IGN;
        end else begin
          m_ptr = int'(b); m_ack = 1'b1; m_st = M_WRITE;
        end
      end
      M_WRITE: begin
        ewe = 1; ewa = m_ptr; m_mem[m_ptr] = b;
        m_ack = 1'b1; m_ack_known = 1'b1; m_ptr = (m_ptr + 1) % 16;
      end
      M_READ: begin
        chk_ack = 1'b0; m_ack_known = 1'b0;
        if (mack) begin
          ere = 1; m_tx = m_mem[m_ptr]; m_ptr = (m_ptr + 1) % 16;
        end else begin
          m_tx = 8'hFF; m_st = M_IGN;
        end
      end
      M_IGN: begin
        m_ack = 1'b0; m_ack_known = 1'b1; m_tx = 8'hFF;
      end
      default: ;
    endcase
    if (chk_ack && m_ack_known) chk("ack", 32'(ack_a), 32'(m_ack));
    chk("tx_byte", 32'(tx_a), 32'(m_tx));
    chk("busy", 32'(busy_a), 32'(m_st == M_PTR || m_st == M_WRITE || m_st == M_READ));
    chk("we_count", 32'(we_cnt - we0), 32'(ewe));
    if (ewe != 0) begin
      chk("we_addr", 32'(last_we_addr), 32'(ewa));
      chk("we_data", 32'(last_we_data), 32'(b));
    end
    chk("re_count", 32'(re_cnt - re0), 32'(ere));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack_a), 32'd0);
    chk({tag, "_tx"}, 32'(tx_a), 32'hFF);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_addr"}, 32'(addr_a), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata_a), 32'd0);
    chk({tag, "_we"}, 32'(we_a), 32'd0);
    chk({tag, "_re"}, 32'(re_a), 32'd0);
  endtask

  initial begin
    int we0, web0, kind, n;
    logic [7:0] b;
    rf_seed = 8'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // 1: simple write
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h03, 1'b0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    xfer(8'h45, 1'b0);
    chk("t1_wdata", 32'(last_we_data), 32'h45);
    do_stop();

    // 2: foreign address
    do_start(); xfer(8'hE4, 1'b0); xfer(8'h11, 1'b0);
    chk("t2_ack", 32'(ack_a), 32'd0);
    do_stop();

    // 3: pointer wrap
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h0F, 1'b0); xfer(8'hAA, 1'b0); xfer(8'hBB, 1'b0);
    chk("t3_wrap_addr", 32'(last_we_addr), 32'h0);
    do_stop();
    do_start(); xfer(8'hE3, 1'b0);
    chk("t3_ptr1_data", 32'(tx_a), 32'(m_mem[1]));
    xfer(8'h00, 1'b0); do_stop();

    // 4: write then repeated-start read
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h02, 1'b0); xfer(8'h5A, 1'b0); xfer(8'hC3, 1'b0); do_stop();
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h02, 1'b0);
    do_start(); xfer(8'hE3, 1'b0);
    chk("t4_tx0", 32'(tx_a), 32'h5A);
    xfer(8'h00, 1'b1);
    chk("t4_tx1", 32'(tx_a), 32'hC3);
    xfer(8'h00, 1'b0);
    chk("t4_nack_tx", 32'(tx_a), 32'hFF);
    do_stop();

    // 5: out-of-range pointer on the 12-register slave
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h05, 1'b0); do_stop();
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h0C, 1'b0);
    chk("t5_ack_b", 32'(ack_b), 32'd0);
    chk("t5_busy_b", 32'(busy_b), 32'd0);
    web0 = we_cnt_b;
    xfer(8'h77, 1'b0);
    chk("t5_we_b", 32'(we_cnt_b - web0), 32'd0);
    chk("t5_ack2_b", 32'(ack_b), 32'd0);
    do_stop();
    do_start(); xfer(8'hE3, 1'b0);
    chk("t5_ptr_b", 32'(last_re_b), 32'd5);
    xfer(8'h00, 1'b0); do_stop();

    // 6a: reset between data byte and its byte_done
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h03, 1'b0);
    we0 = we_cnt;
    @(negedge clk); reset = 1'b1; i_rx_byte = 8'h45; i_byte_done = 1'b1;
    @(negedge clk); i_byte_done = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    model_reset();
    chk("t6_we", 32'(we_cnt - we0), 32'd0);
    check_reset_outputs("t6");
    do_start(); xfer(8'hE3, 1'b0); xfer(8'h00, 1'b0); do_stop();

    // 6b: stop coincident with a data byte
    do_start(); xfer(8'hE2, 1'b0); xfer(8'h05, 1'b0);
    we0 = we_cnt;
    @(negedge clk); i_stop = 1'b1; i_byte_done = 1'b1; i_rx_byte = 8'h99;
    @(negedge clk); i_stop = 1'b0; i_byte_done = 1'b0;
    settle();
    m_st = M_IDLE;
    chk("t6b_we", 32'(we_cnt - we0), 32'd0);
    chk("t6b_busy", 32'(busy_a), 32'd0);
    xfer(8'h12, 1'b0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      do_start();
      case (kind)
        0: begin
          b = 8'($urandom);
          if (b[7:1] == 7'h71) b[7] = 1'b0;
          xfer(b, 1'b0);
          xfer(8'($urandom), 1'($urandom));
        end
        1, 3: begin
          xfer(8'hE2, 1'b0);
          xfer(8'($urandom_range(0, 19)), 1'b0);
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) xfer(8'($urandom), 1'b0);
          if (kind == 3) begin
            do_start(); xfer(8'hE3, 1'b0); xfer(8'h00, 1'b0);
          end
        end
        default: begin
          xfer(8'hE3, 1'b0);
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) xfer(8'h00, (k != n - 1));
        end
      endcase
      if ($urandom_range(0, 3) != 0) do_stop();
    end
    do_stop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_i2c_slave_reg_sequencer
`default_nettype wire
